// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, MTHI/MTLO writes.
// Define MUL_DIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle combinational multiplier.
module mul_div_unit #(
    parameter int  WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rs_value,
    input  logic [WIDTH-1:0] rt_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

`ifdef MUL_DIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   acc_hi_reg, acc_lo_reg, opnd_reg, rs_hold_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, is_mul_reg, res_neg_reg, rem_neg_reg, dvz_reg;

    logic               is_mul_op, is_div_op, signed_op;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH-1:0]   acc_hi_next, acc_lo_next;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_mag, mul_res;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign rs_mag    = (signed_op && rs_value[WIDTH-1]) ? -rs_value : rs_value;
    assign rt_mag    = (signed_op && rt_value[WIDTH-1]) ? -rt_value : rt_value;

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

    // One radix-2 step; acc_hi holds partial product / remainder, acc_lo multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        if (is_mul_reg) begin
            acc_hi_next = mul_sum[WIDTH:1];
            acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end else begin
            acc_hi_next = div_ge ? (div_shift[WIDTH-1:0] - opnd_reg) : div_shift[WIDTH-1:0];
            acc_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};
        end
    end

    // Sign correction and special cases applied on the FINISH edge.
    always_comb begin
`ifdef MUL_DIV_FAST_MUL_EN
        mul_mag = (2*WIDTH)'(opnd_reg) * (2*WIDTH)'(acc_lo_reg);
`else
        mul_mag = {acc_hi_reg, acc_lo_reg};
`endif
        mul_res = res_neg_reg ? -mul_mag : mul_mag;
        if (is_mul_reg) begin
            fin_hi = mul_res[2*WIDTH-1:WIDTH];
            fin_lo = mul_res[WIDTH-1:0];
        end else if (dvz_reg) begin
            fin_hi = rs_hold_reg;
            fin_lo = '1;
        end else begin
            fin_hi = rem_neg_reg ? -acc_hi_reg : acc_hi_reg;
            fin_lo = res_neg_reg ? -acc_lo_reg : acc_lo_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start && (is_mul_op || is_div_op))
                    state_next = (FAST_MUL && is_mul_op) ? FINISH : RUN;
            end
            RUN:     if (cnt_reg == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            opnd_reg    <= '0;
            rs_hold_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
            is_mul_reg  <= 1'b0;
            res_neg_reg <= 1'b0;
            rem_neg_reg <= 1'b0;
            dvz_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && (is_mul_op || is_div_op)) begin
                        cnt_reg     <= CNT_W'(WIDTH);
                        acc_hi_reg  <= '0;
                        acc_lo_reg  <= is_mul_op ? rt_mag : rs_mag;
                        opnd_reg    <= is_mul_op ? rs_mag : rt_mag;
                        rs_hold_reg <= rs_value;
                        is_mul_reg  <= is_mul_op;
                        res_neg_reg <= signed_op && (rs_value[WIDTH-1] ^ rt_value[WIDTH-1]);
                        rem_neg_reg <= signed_op && rs_value[WIDTH-1];
                        dvz_reg     <= (rt_value == '0);
                    end else if (start && (op == OP_MTHI)) begin
                        hi_reg   <= rs_value;
                        done_reg <= 1'b1;
                    end else if (start && (op == OP_MTLO)) begin
                        lo_reg   <= rs_value;
                        done_reg <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    acc_hi_reg <= acc_hi_next;
                    acc_lo_reg <= acc_lo_next;
                end
                FINISH: begin
                    cnt_reg  <= '0;
                    hi_reg   <= fin_hi;
                    lo_reg   <= fin_lo;
                    done_reg <= 1'b1;
                end
                default: cnt_reg <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic HI/LO reference model.
module tb_mul_div_unit;
    localparam int WIDTH = 32;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
`ifdef MUL_DIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [5:0]       op = '0;
    logic [WIDTH-1:0] rs_value = '0;
    logic [WIDTH-1:0] rt_value = '0;
    logic             busy, done;
    logic [WIDTH-1:0] hi_out, lo_out;

    int check_cnt = 0;
    int fail_cnt  = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_value(rs_value), .rt_value(rt_value),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one operation, straight from the instruction definitions.
    task automatic model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_in, input logic [31:0] lo_in,
                         output logic [31:0] hi_o, output logic [31:0] lo_o);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        hi_o = hi_in;
        lo_o = lo_in;
        sa = a;
        sb = b;
        case (o)
            OP_MULT:  begin sp = longint'(sa) * longint'(sb); up = sp; hi_o = up[63:32]; lo_o = up[31:0]; end
            OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; hi_o = up[63:32]; lo_o = up[31:0]; end
            OP_DIV: begin
                if (b == 0) begin lo_o = '1; hi_o = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo_o = a; hi_o = '0; end
                else begin lo_o = sa / sb; hi_o = sa % sb; end
            end
            OP_DIVU: begin
                if (b == 0) begin lo_o = '1; hi_o = a; end
                else begin lo_o = a / b; hi_o = a % b; end
            end
            OP_MTHI: hi_o = a;
            OP_MTLO: lo_o = a;
            default: ;
        endcase
    endtask

    // Issue one op in the current cycle; returns in the cycle where done is seen.
    task automatic do_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit poke_mid);
        logic [31:0] eh, el;
        int k, busy_cnt, exp_lat, extra_done;
        bit seen, stable;
        model(o, a, b, hi_m, lo_m, eh, el);
        start = 1'b1; op = o; rs_value = a; rt_value = b;
        step();
        start = 1'b0; op = 6'($urandom); rs_value = $urandom; rt_value = $urandom;
        if (o == OP_MTHI || o == OP_MTLO) begin
            check_eq({tag, "_mt_done"}, 64'(done), 64'(1));
            check_eq({tag, "_mt_busy"}, 64'(busy), 64'(0));
            check_eq({tag, "_hi"}, 64'(hi_out), 64'(eh));
            check_eq({tag, "_lo"}, 64'(lo_out), 64'(el));
            $display("op=%b rs=%h -> hi=%h lo=%h", o, a, hi_out, lo_out);
            hi_m = eh; lo_m = el;
            return;
        end
        exp_lat  = (FAST_MUL && (o == OP_MULT || o == OP_MULTU)) ? 1 : WIDTH + 1;
        busy_cnt = busy;
        stable   = 1'b1;
        seen     = 1'b0;
        k        = 0;
        while (k < 100 && !seen) begin
            if (poke_mid && k == 10) begin
                start = 1'b1; op = OP_MULTU; rs_value = $urandom; rt_value = $urandom;
            end else begin
                start = 1'b0;
            end
            step();
            k++;
            if (done) seen = 1'b1;
            else begin
                busy_cnt += busy;
                if (hi_out !== hi_m || lo_out !== lo_m) stable = 1'b0;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, 64'(seen), 64'(1));
        check_eq({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check_eq({tag, "_hilo_stable"}, 64'(stable), 64'(1));
        check_eq({tag, "_hi"}, 64'(hi_out), 64'(eh));
        check_eq({tag, "_lo"}, 64'(lo_out), 64'(el));
        $display("op=%b rs=%h rt=%h -> hi=%h lo=%h lat=%0d", o, a, b, hi_out, lo_out, k);
        hi_m = eh; lo_m = el;
        if (poke_mid) begin
            extra_done = 0;
            for (int i = 0; i < WIDTH + 8; i++) begin
                step();
                extra_done += done;
            end
            check_eq({tag, "_no_extra_done"}, 64'(extra_done), 64'(0));
            check_eq({tag, "_idle_after"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] a, b;
        int          dcnt;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

        step(); step();
        reset = 1'b0;
        check_eq("reset_busy", 64'(busy), 64'(0));
        check_eq("reset_done", 64'(done), 64'(0));
        check_eq("reset_hi", 64'(hi_out), 64'(0));
        check_eq("reset_lo", 64'(lo_out), 64'(0));

        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        do_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 1'b0);
        do_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op("mult_small", OP_MULT, 32'd6, 32'd7, 1'b0);
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
        do_op("mthi", OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
        do_op("mtlo", OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);

        // Unrecognised op: nothing happens.
        start = 1'b1; op = 6'b100000; rs_value = $urandom; rt_value = $urandom;
        step();
        start = 1'b0;
        check_eq("bad_op_busy", 64'(busy), 64'(0));
        check_eq("bad_op_done", 64'(done), 64'(0));
        step();
        check_eq("bad_op_done2", 64'(done), 64'(0));
        check_eq("bad_op_hilo", {hi_out, lo_out}, {hi_m, lo_m});
        $display("op=100000 ignored hi=%h lo=%h", hi_out, lo_out);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op("rand", ops[$urandom_range(0, 5)], a, b, 1'b0);
        end

        // Reset in the middle of a divide aborts it without a done.
        start = 1'b1; op = OP_DIV; rs_value = 32'd1000; rt_value = 32'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        check_eq("rst_mid_busy", 64'(busy), 64'(0));
        check_eq("rst_mid_hilo", {hi_out, lo_out}, 64'(0));
        dcnt = 0;
        for (int i = 0; i < WIDTH + 5; i++) begin
            step();
            dcnt += done;
        end
        check_eq("rst_mid_no_done", 64'(dcnt), 64'(0));
        $display("reset mid-op -> hi=%h lo=%h dones=%0d", hi_out, lo_out, dcnt);
        do_op("after_rst", OP_DIVU, 32'd100, 32'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end
endmodule
